// File: rtl/matc_unloader.sv
// Result-memory unloader: reads NUM_WORDS words in order and streams
// them out through a 2-entry skid FIFO with valid/ready flow control.
module matc_unloader #(
   parameter int DATA_W    = 21,
   parameter int ADDR_W    = 12,
   parameter int NUM_WORDS = 1024
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              start,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              fin
);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

   state_t            state;
   logic [DATA_W-1:0] fifo_data [2];
   logic [1:0]        fifo_last;
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        count;
   logic              in_flight;
   logic              in_flight_last;
   logic              xfer;
   logic              at_last;
   logic              final_xfer;
   logic [2:0]        occupancy;

   assign out_valid  = (count != 2'd0);
   assign xfer       = out_valid & out_ready;
   assign out_data   = fifo_data[rd_ptr];
   assign out_last   = out_valid & fifo_last[rd_ptr];
   assign final_xfer = xfer & out_last;
   assign at_last    = (mem_addr == LAST_ADDR);

   // Slots already claimed next cycle; a transfer frees one now.
   assign occupancy = {1'b0, count} + {2'b00, in_flight}
                    - {2'b00, xfer};
   assign mem_rd_en = (state == READ) && (occupancy < 3'd2);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state          <= IDLE;
         mem_addr       <= '0;
         fifo_data[0]   <= '0;
         fifo_data[1]   <= '0;
         fifo_last      <= '0;
         wr_ptr         <= 1'b0;
         rd_ptr         <= 1'b0;
         count          <= 2'd0;
         in_flight      <= 1'b0;
         in_flight_last <= 1'b0;
         busy           <= 1'b0;
         fin            <= 1'b0;
      end else begin
         fin            <= 1'b0;
         in_flight      <= mem_rd_en;
         in_flight_last <= mem_rd_en & at_last;

         if (in_flight) begin
            fifo_data[wr_ptr] <= mem_rdata;
            fifo_last[wr_ptr] <= in_flight_last;
            wr_ptr            <= ~wr_ptr;
         end
         if (xfer)
            rd_ptr <= ~rd_ptr;
         count <= count + 2'(in_flight) - 2'(xfer);

         unique case (state)
            IDLE: begin
               if (start) begin
                  state    <= READ;
                  busy     <= 1'b1;
                  mem_addr <= '0;
               end
            end
            READ: begin
               if (mem_rd_en) begin
                  if (at_last)
                     state <= DRAIN;
                  else
                     mem_addr <= mem_addr + 1'b1;
               end
            end
            DRAIN: begin
               if (final_xfer) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  fin   <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matc_unloader.sv
// Randomized scoreboard bench for matc_unloader, plus a
// single-word instance for the NUM_WORDS=1 corner.
module tb_matc_unloader;

   localparam int DW = 21;
   localparam int AW = 12;
   localparam int NW = 1024;

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
   } exp_t;

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic          start = 1'b0;
   logic          out_ready = 1'b0;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata = '0;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          busy;
   logic          fin;

   logic          start1 = 1'b0;
   logic          ready1 = 1'b1;
   logic          rd1;
   logic [0:0]    addr1;
   logic [DW-1:0] rdata1 = '0;
   logic          v1;
   logic [DW-1:0] d1;
   logic          l1;
   logic          b1;
   logic          f1;

   logic [DW-1:0] mem [NW];
   exp_t          q[$];
   exp_t          e;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int reads = 0;
   int xfers = 0;
   int fins = 0;
   int first_cyc = 0;
   int last_cyc = 0;
   int rd_expect = 0;
   int ready_mode = 0;
   int fins_before = 0;
   bit model_active = 0;
   bit exp_fin = 0;
   bit stalled = 0;
   logic [DW-1:0] st_data = '0;
   logic          st_last = 1'b0;

   matc_unloader #(.DATA_W(DW), .ADDR_W(AW), .NUM_WORDS(NW)) dut (
      .clk(clk), .nrst(nrst), .start(start),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy), .fin(fin)
   );

   matc_unloader #(.DATA_W(DW), .ADDR_W(1), .NUM_WORDS(1)) u1 (
      .clk(clk), .nrst(nrst), .start(start1),
      .mem_rd_en(rd1), .mem_addr(addr1),
      .mem_rdata(rdata1), .out_valid(v1),
      .out_ready(ready1), .out_data(d1),
      .out_last(l1), .busy(b1), .fin(f1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr[9:0]];
   always @(posedge clk) if (rd1) rdata1 <= 21'h1ABCD;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
      #2;
      case (ready_mode)
         0: out_ready = 1'b0;
         1: out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: scoreboard pop, stall stability, read order, fin timing.
   initial forever begin
      @(negedge clk);
      if (nrst) begin
         if (exp_fin) begin
            chk("fin_pulse", 32'(fin), 32'd1);
            chk("fin_busy_low", 32'(busy), 32'd0);
            exp_fin = 0;
         end else if (fin) begin
            chk("fin_spurious", 32'(fin), 32'd0);
         end
         if (fin) fins++;
         if (mem_rd_en) begin
            reads++;
            chk("rd_order", 32'(mem_addr), 32'(rd_expect));
            chk("addr_bound", 32'(mem_addr <= AW'(NW - 1)), 32'd1);
            rd_expect++;
         end
         if (stalled) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(st_data));
            chk("stall_last", 32'(out_last), 32'(st_last));
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_xfer", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               chk("xfer_data", 32'(out_data), 32'(e.d));
               chk("xfer_last", 32'(out_last), 32'(e.l));
            end
            if (xfers == 0) first_cyc = cyc;
            last_cyc = cyc;
            xfers++;
            if (out_last) begin
               exp_fin = 1;
               model_active = 0;
            end
         end
         stalled = out_valid && !out_ready;
         st_data = out_data;
         st_last = out_last;
      end
   end

   task automatic do_start();
      @(posedge clk);
      #1;
      if (!model_active) begin
         model_active = 1;
         rd_expect = 0;
         reads = 0;
         xfers = 0;
         for (int i = 0; i < NW; i++)
            q.push_back('{d: DW'(i * 3), l: (i == NW - 1)});
      end
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((model_active || q.size() != 0) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20000) chk("timeout_done", 32'd0, 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_xfers(input int target);
      int n;
      n = 0;
      while (xfers < target && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20000) chk("timeout_xfers", 32'd0, 32'd1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
      chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_data"}, 32'(out_data), 32'd0);
      chk({tag, "_last"}, 32'(out_last), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_fin"}, 32'(fin), 32'd0);
   endtask

   initial begin
      int n;
      for (int i = 0; i < NW; i++) mem[i] = DW'(i * 3);
      #1 chk_zero("rst");
      repeat (3) @(posedge clk);
      #1 nrst = 1'b1;

      // Full-rate stream with latency and throughput checks.
      ready_mode = 1;
      fins_before = fins;
      do_start();
      @(negedge clk) chk("lat_e0", 32'(out_valid), 32'd0);
      @(negedge clk) chk("lat_e1", 32'(out_valid), 32'd0);
      @(negedge clk) chk("lat_e2", 32'(out_valid), 32'd1);
      wait_done();
      chk("a_xfers", 32'(xfers), 32'(NW));
      chk("a_thru", 32'(last_cyc - first_cyc + 1), 32'(NW));
      chk("a_fins", 32'(fins), 32'(fins_before + 1));
      chk("a_reads", 32'(reads), 32'(NW));

      // Random backpressure.
      ready_mode = 2;
      fins_before = fins;
      do_start();
      wait_done();
      chk("b_xfers", 32'(xfers), 32'(NW));
      chk("b_fins", 32'(fins), 32'(fins_before + 1));

      // Long stall right after the first word appears.
      ready_mode = 0;
      fins_before = fins;
      do_start();
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("c_first_valid", 32'(out_valid), 32'd1);
      repeat (20) @(negedge clk);
      chk("c_stall_reads", 32'(reads), 32'd2);
      ready_mode = 1;
      wait_done();
      chk("c_xfers", 32'(xfers), 32'(NW));
      chk("c_fins", 32'(fins), 32'(fins_before + 1));

      // Restart attempt mid-run must be ignored.
      ready_mode = 2;
      fins_before = fins;
      do_start();
      wait_xfers(500);
      do_start();
      wait_done();
      chk("d_xfers", 32'(xfers), 32'(NW));
      chk("d_fins", 32'(fins), 32'(fins_before + 1));

      // Asynchronous reset mid-run, then a fresh run.
      ready_mode = 2;
      do_start();
      wait_xfers(300);
      #2 nrst = 1'b0;
      #1 chk_zero("mid_rst");
      q.delete();
      model_active = 0;
      exp_fin = 0;
      stalled = 0;
      repeat (3) @(posedge clk);
      #1 nrst = 1'b1;
      fins_before = fins;
      do_start();
      wait_done();
      chk("e_xfers", 32'(xfers), 32'(NW));
      chk("e_fins", 32'(fins), 32'(fins_before + 1));

      // Single-word instance.
      @(posedge clk);
      #1 start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      @(negedge clk);
      chk("w1_rd_en", 32'(rd1), 32'd1);
      chk("w1_addr", 32'(addr1), 32'd0);
      chk("w1_busy", 32'(b1), 32'd1);
      @(negedge clk);
      chk("w1_rd_once", 32'(rd1), 32'd0);
      chk("w1_lat1", 32'(v1), 32'd0);
      @(negedge clk);
      chk("w1_valid", 32'(v1), 32'd1);
      chk("w1_data", 32'(d1), 32'h1ABCD);
      chk("w1_last", 32'(l1), 32'd1);
      @(negedge clk);
      chk("w1_fin", 32'(f1), 32'd1);
      chk("w1_busy_low", 32'(b1), 32'd0);
      chk("w1_valid_low", 32'(v1), 32'd0);
      @(negedge clk);
      chk("w1_fin_once", 32'(f1), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/matc_unloader.md
MATC_UNLOADER -- requirements
Module: matc_unloader

Interface
REQ-001 Parameter: DATA_W, 21, result word width.
REQ-002 Parameter: ADDR_W, 12, result memory address width.
REQ-003 Parameter: NUM_WORDS, 1024, words read per run (1..2^ADDR_W).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 nrst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  run request (driven by top_controller done); sampled on rising edge.
REQ-007 mem_rd_en  output  1  result-memory read strobe.
REQ-008 mem_addr  output  ADDR_W  result-memory read address.
REQ-009 mem_rdata  input  DATA_W  result-memory read data; valid on the cycle after mem_rd_en.
REQ-010 out_valid  output  1  out_data holds a valid word.
REQ-011 out_ready  input  1  downstream accepts; transfer = out_valid & out_ready at rising edge.
REQ-012 out_data  output  DATA_W  streamed result word.
REQ-013 out_last  output  1  high with the word from address NUM_WORDS-1.
REQ-014 busy  output  1  high from run acceptance until the final transfer completes.
REQ-015 fin  output  1  one-cycle pulse after the final transfer.

Function
REQ-016 States IDLE, READ, DRAIN; IDLE -> READ when start sampled high in IDLE; READ -> DRAIN on the edge issuing the read of address NUM_WORDS-1; DRAIN -> IDLE on the edge completing the transfer with out_last high.
REQ-017 start is ignored outside IDLE, including on the edge where the state returns to IDLE.
REQ-018 Reads issue in ascending order from address 0 to NUM_WORDS-1, each address exactly once per run; mem_addr never exceeds NUM_WORDS-1 and never wraps.
REQ-019 Read data is captured into a 2-entry FIFO on the edge after the read issues; out_data/out_valid come from the FIFO head.
REQ-020 A read issues in a cycle only in READ and only when (entries held + reads in flight - transfer this cycle) < 2; FIFO never overflows, and no read data is dropped.
REQ-021 Latency: the first out_valid rises on the second rising edge after start is sampled.
REQ-022 Throughput: with out_ready held high, one transfer per cycle, NUM_WORDS transfers in NUM_WORDS consecutive cycles.
REQ-023 While out_valid is high and out_ready is low, out_data and out_last remain stable and out_valid stays high.
REQ-024 out_ready may toggle arbitrarily; word order and content are unaffected.
REQ-025 mem_rd_en is low in IDLE and DRAIN; mem_addr holds its last value when mem_rd_en is low.
REQ-026 fin is high for exactly one cycle, the cycle after the final transfer edge; busy is low in that same cycle.
REQ-027 NUM_WORDS=1: single word with out_last high; READ -> DRAIN on the edge issuing the read of address 0.

Reset
REQ-028 nrst low asynchronously forces IDLE, FIFO empty, no reads in flight, address counter 0, and all outputs low/zero (mem_rd_en, mem_addr, out_valid, out_data, out_last, busy, fin).
REQ-029 Reset mid-run abandons the run; after release, the block waits in IDLE for a new start and restarts from address 0.

Verification
REQ-030 Memory loaded with word i = i*3 mod 2^21, start pulse, out_ready=1 -> 1024 words 0,3,6,... in 1024 consecutive cycles, out_last only with word 3069, fin single pulse.
REQ-031 Same load, out_ready random 50% -> identical sequence, no duplicates/drops, out_data stable during every stall, mem_addr never exceeds 1023.
REQ-032 out_ready held low 20 cycles after first out_valid -> exactly 2 reads issued (addrs 0,1), no further mem_rd_en until the stall ends.
REQ-033 start pulsed again at transfer 500 -> ignored; exactly 1024 transfers and one fin.
REQ-034 nrst low at transfer 300 -> all outputs zero immediately; new start after release -> stream restarts at address 0 with 1024 words.
REQ-035 End-to-end with top_controller: done drives start -> streamed words match expected vec_c contents, error count 0.
